cassette_progress: RTL and testbench



---
 rtl/cassette_progress.sv | 120 ++++++++++++
 tb/tb_cassette_progress.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cassette_progress.sv
// Feeds the cassette progress overlay: image size (max), bytes consumed (pos), visibility (ena), end flag (eof).
// Latency: every output is registered, one cycle after the input that causes it; no backpressure (strobes are never stalled).
module cassette_progress #(
    parameter logic [26:0] TIMEOUT = 27'd96_000_000
) (
    input  logic        i_clk,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic        rd_req,
    input  logic        motor,
    input  logic        rewind,
    input  logic        show_always,
    output logic [24:0] max,
    output logic [24:0] pos,
    output logic        ena,
    output logic        eof
);
    typedef enum logic [1:0] {S_EMPTY, S_LOADING, S_STOPPED, S_PLAYING} state_t;

    state_t      r_state;
    logic [24:0] r_size;
    logic [26:0] r_timer;

    logic [25:0] w_addr_p1;
    logic [24:0] w_wr_size;
    logic [24:0] w_size_nxt;
    logic [24:0] w_pos_inc;
    logic [26:0] w_timer_dec;
    logic        w_count;
    logic        w_at_end;

    // Writes may arrive out of order, so size tracks the highest address seen.
    assign w_addr_p1   = {1'b0, dl_addr} + 26'd1;
    assign w_wr_size   = w_addr_p1[25] ? 25'h1FF_FFFF : w_addr_p1[24:0];
    assign w_size_nxt  = (dl_wr && (w_wr_size > r_size)) ? w_wr_size : r_size;
    assign w_pos_inc   = (pos < max) ? pos + 25'd1 : pos;
    assign w_at_end    = (pos == max);
    assign w_timer_dec = (r_timer == 27'd0) ? 27'd0 : r_timer - 27'd1;
    assign w_count     = rd_req && ((r_state == S_PLAYING) ||
                                    ((r_state == S_STOPPED) && motor));

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_size  <= 25'd0;
            r_timer <= 27'd0;
            max     <= 25'd0;
            pos     <= 25'd0;
            ena     <= 1'b0;
            eof     <= 1'b0;
        end else if (dl_active && (r_state != S_LOADING)) begin
            r_state <= S_LOADING;
            r_size  <= 25'd0;
            r_timer <= 27'd0;
            pos     <= 25'd0;
            ena     <= 1'b0;
            eof     <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    ena <= 1'b0;
                end
                S_LOADING: begin
                    r_size <= w_size_nxt;
                    ena    <= 1'b0;
                    if (!dl_active) begin
                        if (w_size_nxt == 25'd0) begin
                            r_state <= S_EMPTY;
                            max     <= 25'd0;
                        end else begin
                            r_state <= S_STOPPED;
                            max     <= w_size_nxt;
                            pos     <= 25'd0;
                            r_timer <= TIMEOUT;
                            ena     <= 1'b1;
                        end
                    end
                end
                S_STOPPED: begin
                    if (rewind) begin
                        pos <= 25'd0;
                        eof <= 1'b0;
                    end else begin
                        if (w_count) pos <= w_pos_inc;
                        eof <= w_at_end;
                    end
                    // A rewind restarts the hold so the user sees the bar clear.
                    if (motor) begin
                        r_state <= S_PLAYING;
                        r_timer <= TIMEOUT;
                        ena     <= 1'b1;
                    end else if (rewind) begin
                        r_timer <= TIMEOUT;
                        ena     <= 1'b1;
                    end else begin
                        r_timer <= w_timer_dec;
                        ena     <= show_always || (w_timer_dec != 27'd0);
                    end
                end
                S_PLAYING: begin
                    if (rewind) begin
                        pos <= 25'd0;
                        eof <= 1'b0;
                    end else begin
                        if (w_count) pos <= w_pos_inc;
                        eof <= w_at_end;
                    end
                    r_timer <= TIMEOUT;
                    ena     <= 1'b1;
                    if (!motor) r_state <= S_STOPPED;
                end
                default: begin
                    r_state <= S_EMPTY;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cassette_progress.sv
// Bench for cassette_progress: vectors carry inputs plus expected outputs one cycle later.
module tb_cassette_progress;
    localparam logic [26:0] T  = 27'd16;
    localparam int          TI = 16;
    localparam logic [24:0] Z    = 25'd0;
    localparam logic [24:0] C100 = 25'd100;
    localparam logic [24:0] C20  = 25'd20;
    localparam logic [24:0] MAXA = 25'h1FF_FFFF;

    logic        i_clk = 1'b0;
    logic        reset, dl_active, dl_wr, rd_req, motor, rewind, show_always;
    logic [24:0] dl_addr;
    logic [24:0] max, pos;
    logic        ena, eof;

    cassette_progress #(.TIMEOUT(T)) dut (
        .i_clk(i_clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .rd_req(rd_req), .motor(motor), .rewind(rewind),
        .show_always(show_always), .max(max), .pos(pos), .ena(ena), .eof(eof)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rst, da, wr;
        logic [24:0] addr;
        logic        rd, mot, rw, sa;
        logic [24:0] emax, epos;
        logic        eena, eeof;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic rst, input logic da, input logic wr,
                                input logic [24:0] addr, input logic rd, input logic mot,
                                input logic rw, input logic sa, input logic [24:0] emax,
                                input logic [24:0] epos, input logic eena, input logic eeof);
        vec_t v;
        v.rst = rst; v.da = da; v.wr = wr; v.addr = addr;
        v.rd = rd; v.mot = mot; v.rw = rw; v.sa = sa;
        v.emax = emax; v.epos = epos; v.eena = eena; v.eeof = eeof;
        return v;
    endfunction

    task automatic step(input vec_t v, input string nm);
        vec_t e;
        reset = v.rst; dl_active = v.da; dl_wr = v.wr; dl_addr = v.addr;
        rd_req = v.rd; motor = v.mot; rewind = v.rw; show_always = v.sa;
        sb.push_back(v);
        @(posedge i_clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (max !== e.emax || pos !== e.epos || ena !== e.eena || eof !== e.eeof) begin
            errors++;
            $display("FAIL %s: got max=%0d pos=%0d ena=%0b eof=%0b, expected max=%0d pos=%0d ena=%0b eof=%0b",
                     nm, max, pos, ena, eof, e.emax, e.epos, e.eena, e.eeof);
        end
    endtask

    task automatic run(input logic da, input logic wr, input logic [24:0] addr,
                       input logic rd, input logic mot, input logic rw, input logic sa,
                       input logic [24:0] emax, input logic [24:0] epos,
                       input logic eena, input logic eeof, input string nm);
        step(mk(1'b0, da, wr, addr, rd, mot, rw, sa, emax, epos, eena, eeof), nm);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = Z;
        rd_req = 1'b0; motor = 1'b0; rewind = 1'b0; show_always = 1'b0;

        step(mk(1, 0, 0, Z, 0, 0, 0, 0, Z, Z, 0, 0), "reset0");
        step(mk(1, 0, 0, Z, 0, 0, 0, 0, Z, Z, 0, 0), "reset1");

        // Load 100 bytes (with a repeated address), then hold-off, then play to the end.
        tbl.push_back(mk(0, 1, 0, Z, 0, 0, 0, 0, Z, Z, 0, 0));
        for (int a = 0; a < 100; a++)
            tbl.push_back(mk(0, 1, 1, 25'(a), 0, 0, 0, 0, Z, Z, 0, 0));
        tbl.push_back(mk(0, 1, 1, 25'd40, 0, 0, 0, 0, Z, Z, 0, 0));
        tbl.push_back(mk(0, 0, 0, Z, 0, 0, 0, 0, C100, Z, 1, 0));
        for (int k = 1; k < TI; k++)
            tbl.push_back(mk(0, 0, 0, Z, 0, 0, 0, 0, C100, Z, 1, 0));
        tbl.push_back(mk(0, 0, 0, Z, 0, 0, 0, 0, C100, Z, 0, 0));
        tbl.push_back(mk(0, 0, 0, Z, 0, 0, 0, 0, C100, Z, 0, 0));
        for (int i = 1; i <= 100; i++)
            tbl.push_back(mk(0, 0, 0, Z, 1, 1, 0, 0, C100, 25'(i), 1, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0, 0, Z, 1, 1, 0, 0, C100, C100, 1, 1));
        foreach (tbl[i]) step(tbl[i], $sformatf("load_play_vec%0d", i));

        // Motor stop hold-off, then show_always.
        run(0, 0, Z, 0, 0, 0, 0, C100, C100, 1, 1, "motor_stop");
        for (int k = 1; k < TI; k++) run(0, 0, Z, 0, 0, 0, 0, C100, C100, 1, 1, "stop_hold");
        run(0, 0, Z, 0, 0, 0, 0, C100, C100, 0, 1, "stop_expire");
        for (int k = 0; k < 20; k++) run(0, 0, Z, 0, 0, 0, 1, C100, C100, 1, 1, "show_always");
        run(0, 0, Z, 0, 0, 0, 0, C100, C100, 0, 1, "show_off");

        // Rewind in STOPPED restarts the hold; rd_req is ignored while stopped.
        run(0, 0, Z, 0, 0, 1, 0, C100, Z, 1, 0, "rewind_stopped");
        for (int k = 1; k < TI; k++) run(0, 0, Z, 1, 0, 0, 0, C100, Z, 1, 0, "rd_stopped");
        run(0, 0, Z, 1, 0, 0, 0, C100, Z, 0, 0, "rewind_hold_expire");
        run(0, 0, Z, 0, 1, 0, 0, C100, Z, 1, 0, "play_start");
        for (int i = 1; i <= 57; i++) run(0, 0, Z, 1, 1, 0, 0, C100, 25'(i), 1, 0, "count57");
        run(0, 0, Z, 1, 1, 1, 0, C100, Z, 1, 0, "rewind_collision");

        // Motor drop with coincident rd_req, then reload mid-play.
        for (int i = 1; i <= 29; i++) run(0, 0, Z, 1, 1, 0, 0, C100, 25'(i), 1, 0, "count30");
        run(0, 0, Z, 1, 0, 0, 0, C100, 25'd30, 1, 0, "motor_drop_rd");
        run(0, 0, Z, 0, 1, 0, 0, C100, 25'd30, 1, 0, "replay");
        run(1, 0, Z, 1, 1, 0, 0, C100, Z, 0, 0, "reload_abort");
        for (int a = 0; a < 20; a++) run(1, 1, 25'(a), 1, 1, 0, 0, C100, Z, 0, 0, "reload_wr");
        run(1, 1, 25'd5, 1, 1, 0, 0, C100, Z, 0, 0, "reload_wr_repeat");
        run(0, 0, Z, 0, 0, 0, 0, C20, Z, 1, 0, "reload_done");
        run(1, 0, Z, 0, 0, 0, 0, C20, Z, 0, 0, "empty_load_start");
        run(1, 0, Z, 0, 0, 0, 0, C20, Z, 0, 0, "empty_load_wait");
        run(0, 0, Z, 0, 0, 0, 0, Z, Z, 0, 0, "empty_load_done");
        run(0, 0, Z, 1, 1, 1, 0, Z, Z, 0, 0, "empty_ignored");
        run(0, 0, Z, 1, 1, 0, 0, Z, Z, 0, 0, "empty_ignored2");

        // Top-of-range address saturates the size.
        run(1, 0, Z, 0, 0, 0, 0, Z, Z, 0, 0, "sat_start");
        run(1, 1, MAXA, 0, 0, 0, 0, Z, Z, 0, 0, "sat_wr");
        run(0, 0, Z, 0, 0, 0, 0, MAXA, Z, 1, 0, "sat_done");

        // Reset mid-play.
        for (int i = 1; i <= 10; i++) run(0, 0, Z, 1, 1, 0, 0, MAXA, 25'(i), 1, 0, "count10");
        step(mk(1, 0, 0, Z, 1, 1, 0, 0, Z, Z, 0, 0), "reset_mid_play");
        run(0, 0, Z, 1, 1, 0, 0, Z, Z, 0, 0, "after_reset0");
        run(0, 0, Z, 1, 1, 0, 0, Z, Z, 0, 0, "after_reset1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
